// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the arbiter and the SRAM port.
// The arbiter takes the slave view; the requester/SRAM side takes master.
interface sram_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport slave (
        input  if_req, if_addr,
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        input  sram_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output if_req, if_addr,
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        output sram_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM port between fetch (IF) and data (MEM).
// One access in flight; MEM wins unless IF has waited MAX_STREAK MEM grants.
module sram_port_arbiter #(
    parameter int RD_LAT     = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    sram_port_arbiter_if.slave bus
);

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_WAIT     = 1'b1;
    localparam logic [1:0] CNT_LOAD   = 2'(RD_LAT - 1);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    logic [0:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] streak_q, streak_d;
    logic       owner_q, owner_d;

    logic resp;
    logic arb_ok;
    logic force_if;
    logic gnt_mem;
    logic gnt_if;
    logic gnt_rd;
    logic mem_st;

    // Arbitration decision and next-state for FSM, latency, streak, owner
    always_comb begin
        resp     = (state_q == S_WAIT) && (cnt_q == 2'd0);
        arb_ok   = !reset && ((state_q == S_IDLE) || resp);
        force_if = bus.if_req && (streak_q == STREAK_MAX);
        gnt_mem  = arb_ok && bus.mem_req && !force_if;
        gnt_if   = arb_ok && !gnt_mem && bus.if_req;
        mem_st   = gnt_mem && bus.mem_wr;
        gnt_rd   = gnt_if || (gnt_mem && !bus.mem_wr);

        state_d  = state_q;
        cnt_d    = cnt_q;
        streak_d = streak_q;
        owner_d  = owner_q;

        if ((state_q == S_WAIT) && (cnt_q != 2'd0)) begin
            cnt_d = cnt_q - 2'd1;
        end else if (gnt_rd) begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
            owner_d = gnt_mem;
        end else begin
            state_d = S_IDLE;
            cnt_d   = 2'd0;
        end

        if (gnt_mem) begin
            if (!bus.if_req)
                streak_d = 4'd0;
            else if (streak_q != STREAK_MAX)
                streak_d = streak_q + 4'd1;
        end else if (gnt_if) begin
            streak_d = 4'd0;
        end
    end

    // Port outputs: grant-cycle SRAM drive and owner-steered read return
    always_comb begin
        bus.if_gnt     = gnt_if;
        bus.mem_gnt    = gnt_mem;
        bus.sram_en    = gnt_if || gnt_mem;
        bus.sram_addr  = gnt_mem ? bus.mem_addr :
                         gnt_if  ? bus.if_addr  : 32'h0;
        bus.sram_we    = mem_st ? bus.mem_wstrb : 4'h0;
        bus.sram_wdata = mem_st ? bus.mem_wdata : 32'h0;
        bus.if_rvalid  = !reset && resp && !owner_q;
        bus.mem_rvalid = !reset && resp && owner_q;
        bus.if_rdata   = bus.if_rvalid  ? bus.sram_rdata : 32'h0;
        bus.mem_rdata  = bus.mem_rvalid ? bus.sram_rdata : 32'h0;
    end

    // State registers; reset drops any outstanding read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 2'd0;
            streak_q <= 4'd0;
            owner_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            streak_q <= streak_d;
            owner_q  <= owner_d;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized scoreboard bench for sram_port_arbiter.
// Two instances (RD_LAT 1 and 3) each with their own model and monitor.
module tb_sram_port_arbiter;

    typedef struct {
        int          cyc;
        bit          who;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct {
        int          cyc;
        bit          who;
        logic [31:0] data;
    } rsp_t;

    localparam int NCYC = 1500;

    logic     clk = 1'b0;
    int       checks = 0;
    int       errors = 0;
    bit [1:0] done = 2'b00;

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : env
        localparam int RL = (g == 0) ? 1 : 3;
        localparam int MS = (g == 0) ? 4 : 2;

        logic rst;
        int   cyc;
        gnt_t gq[$];
        rsp_t rq[$];

        sram_port_arbiter_if bus ();

        sram_port_arbiter #(.RD_LAT(RL), .MAX_STREAK(MS)) u_dut (
            .clk   (clk),
            .reset (rst),
            .bus   (bus)
        );

        // Stimulus plus reference model: decides expected grants/responses
        initial begin : drv
            bit          ip, mp, mw, resp, free, g_m, g_i, rown;
            logic [31:0] ia, ma, md, rd;
            logic [3:0]  ms;
            int          resp_cyc, streak;
            ip = 0; mp = 0; mw = 0; rown = 0;
            ia = 0; ma = 0; md = 0; ms = 0; rd = 0;
            resp_cyc = -1; streak = 0; cyc = 0;
            rst = 1'b1;
            bus.if_req = 0; bus.if_addr = 0;
            bus.mem_req = 0; bus.mem_wr = 0; bus.mem_wstrb = 0;
            bus.mem_addr = 0; bus.mem_wdata = 0; bus.sram_rdata = 0;
            for (int c = 0; c < NCYC; c++) begin
                @(negedge clk);
                cyc = c;
                if (c < 3 || c == 51) begin
                    rst = 1'b1;
                    ip = 0; mp = 0; resp_cyc = -1; streak = 0;
                    bus.if_req = 0;
                    bus.mem_req = 0;
                end else begin
                    rst = 1'b0;
                    case (c)
                        3:  begin ip = 1; ia = 32'h1c000000; end
                        8:  begin
                                ip = 1; ia = 32'h1c000004;
                                mp = 1; mw = 0; ma = 32'h100;
                                ms = 4'($urandom); md = $urandom;
                            end
                        16: begin
                                mp = 1; mw = 1; ms = 4'b0011;
                                ma = 32'h200; md = 32'haabbccdd;
                            end
                        17: begin ip = 1; ia = 32'h1c000008; end
                        22: begin
                                mp = 1; mw = 1; ms = 4'b0000;
                                ma = 32'h204; md = 32'h12345678;
                            end
                        50: begin mp = 1; mw = 0; ma = 32'h300; end
                        default: ;
                    endcase
                    if (c >= 24 && c <= 40) begin
                        if (!ip) begin ip = 1; ia = $urandom; end
                        if (!mp) begin mp = 1; mw = 0; ma = $urandom; end
                    end
                    if (c >= 55 && c < NCYC - 10) begin
                        if (!ip && $urandom_range(0, 99) < 50) begin
                            ip = 1; ia = $urandom;
                        end
                        if (!mp && $urandom_range(0, 99) < 50) begin
                            mp = 1; mw = ($urandom_range(0, 2) == 0);
                            ms = 4'($urandom); ma = $urandom; md = $urandom;
                        end
                    end
                    bus.if_req    = ip;
                    bus.if_addr   = ip ? ia : $urandom;
                    bus.mem_req   = mp;
                    bus.mem_wr    = mp ? mw : 1'($urandom);
                    bus.mem_wstrb = mp ? ms : 4'($urandom);
                    bus.mem_addr  = mp ? ma : $urandom;
                    bus.mem_wdata = mp ? md : $urandom;
                    rd = (c < 24) ? 32'h02800c0c : $urandom;
                    bus.sram_rdata = rd;

                    resp = (resp_cyc == c);
                    free = resp || (resp_cyc < 0);
                    if (resp) begin
                        rq.push_back('{c, rown, rd});
                        resp_cyc = -1;
                    end
                    g_m = free && mp && !(ip && streak == MS);
                    g_i = free && !g_m && ip;
                    if (g_m) begin
                        gq.push_back('{c, 1'b1, ma, mw ? ms : 4'h0,
                                       mw ? md : 32'h0});
                        if (!ip) streak = 0;
                        else if (streak < MS) streak = streak + 1;
                        if (!mw) begin
                            resp_cyc = c + RL;
                            rown = 1;
                        end
                        mp = 0;
                    end else if (g_i) begin
                        gq.push_back('{c, 1'b0, ia, 4'h0, 32'h0});
                        streak = 0;
                        resp_cyc = c + RL;
                        rown = 0;
                        ip = 0;
                    end
                end
            end
            repeat (2) @(negedge clk);
            #2;
            chk(gq.size() == 0 && rq.size() == 0,
                $sformatf("L%0d queues drained", RL),
                64'(gq.size() + rq.size()), 64'h0);
            done[g] = 1'b1;
        end

        // Monitor: pops expectations whenever the DUT grants or returns data
        initial begin : mon
            gnt_t ge;
            rsp_t re;
            bit   miss;
            forever begin
                @(negedge clk);
                #1;
                if (rst) begin
                    chk(!(bus.if_gnt || bus.mem_gnt || bus.if_rvalid ||
                          bus.mem_rvalid || bus.sram_en) &&
                        bus.sram_we == 0 && bus.sram_addr == 0 &&
                        bus.sram_wdata == 0 && bus.if_rdata == 0 &&
                        bus.mem_rdata == 0,
                        $sformatf("L%0d reset outputs", RL),
                        {bus.sram_addr, 27'h0, bus.if_gnt, bus.mem_gnt,
                         bus.if_rvalid, bus.mem_rvalid, bus.sram_en},
                        64'h0);
                end else begin
                    if (bus.if_gnt || bus.mem_gnt) begin
                        chk(gq.size() != 0,
                            $sformatf("L%0d grant expected c%0d", RL, cyc),
                            64'({bus.if_gnt, bus.mem_gnt}), 64'h0);
                        if (gq.size() != 0) begin
                            ge = gq.pop_front();
                            chk(ge.cyc == cyc,
                                $sformatf("L%0d grant cycle", RL),
                                64'(cyc), 64'(ge.cyc));
                            chk(bus.mem_gnt == ge.who && bus.if_gnt == !ge.who,
                                $sformatf("L%0d grant port c%0d", RL, cyc),
                                64'({bus.if_gnt, bus.mem_gnt}),
                                ge.who ? 64'h1 : 64'h2);
                            chk(bus.sram_en && bus.sram_addr == ge.addr,
                                $sformatf("L%0d grant addr", RL),
                                {31'h0, bus.sram_en, bus.sram_addr},
                                {32'h1, ge.addr});
                            chk(bus.sram_we == ge.we &&
                                bus.sram_wdata == ge.wdata,
                                $sformatf("L%0d grant write", RL),
                                {28'h0, bus.sram_we, bus.sram_wdata},
                                {28'h0, ge.we, ge.wdata});
                        end
                    end else begin
                        chk(!bus.sram_en && bus.sram_we == 0 &&
                            bus.sram_addr == 0 && bus.sram_wdata == 0,
                            $sformatf("L%0d idle bus", RL),
                            {bus.sram_addr, bus.sram_wdata}, 64'h0);
                        miss = (gq.size() != 0) && (gq[0].cyc <= cyc);
                        chk(!miss, $sformatf("L%0d missing grant c%0d", RL, cyc),
                            64'(cyc), miss ? 64'(gq[0].cyc) : 64'h0);
                        if (miss) void'(gq.pop_front());
                    end
                    if (bus.if_rvalid || bus.mem_rvalid) begin
                        chk(rq.size() != 0,
                            $sformatf("L%0d response expected c%0d", RL, cyc),
                            64'({bus.if_rvalid, bus.mem_rvalid}), 64'h0);
                        if (rq.size() != 0) begin
                            re = rq.pop_front();
                            chk(re.cyc == cyc,
                                $sformatf("L%0d response cycle", RL),
                                64'(cyc), 64'(re.cyc));
                            chk(bus.mem_rvalid == re.who &&
                                bus.if_rvalid == !re.who,
                                $sformatf("L%0d response port", RL),
                                64'({bus.if_rvalid, bus.mem_rvalid}),
                                re.who ? 64'h1 : 64'h2);
                            chk(re.who ? (bus.mem_rdata == re.data &&
                                          bus.if_rdata == 0)
                                       : (bus.if_rdata == re.data &&
                                          bus.mem_rdata == 0),
                                $sformatf("L%0d response data", RL),
                                {bus.if_rdata, bus.mem_rdata},
                                re.who ? {32'h0, re.data} : {re.data, 32'h0});
                        end
                    end else begin
                        chk(bus.if_rdata == 0 && bus.mem_rdata == 0,
                            $sformatf("L%0d idle rdata", RL),
                            {bus.if_rdata, bus.mem_rdata}, 64'h0);
                        miss = (rq.size() != 0) && (rq[0].cyc <= cyc);
                        chk(!miss,
                            $sformatf("L%0d missing response c%0d", RL, cyc),
                            64'(cyc), miss ? 64'(rq[0].cyc) : 64'h0);
                        if (miss) void'(rq.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        wait (done == 2'b11);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single synchronous data/instruction SRAM port of the multicycle core between two requesters: the fetch stage (IF) and the memory stage (MEM).
- One access is outstanding at a time, matching the non-pipelined state sequencing.
- Data requests have priority over fetch, with a starvation guard so fetch is still served.
- Read data is returned to the requester that issued the read, with a response pulse.

Parameters:
- RD_LAT, 1, SRAM read latency in cycles from the enable cycle to valid sram_rdata. Legal range 1..4.
- MAX_STREAK, 4, maximum consecutive MEM grants while if_req is pending before IF is forced. Legal range 1..15.

Ports:
- clk input 1 system clock
- reset input 1 asynchronous, active-high reset
- if_req input 1 fetch read request; held until if_gnt
- if_addr input 32 fetch byte address
- if_gnt output 1 fetch request accepted this cycle
- if_rvalid output 1 fetch read data valid this cycle
- if_rdata output 32 fetch read data
- mem_req input 1 data request; held with its fields until mem_gnt
- mem_wr input 1 1 = store, 0 = load
- mem_wstrb input 4 store byte enables
- mem_addr input 32 data byte address
- mem_wdata input 32 store data
- mem_gnt output 1 data request accepted this cycle
- mem_rvalid output 1 load data valid this cycle
- mem_rdata output 32 load data
- sram_en output 1 SRAM access enable
- sram_we output 4 SRAM byte write enables
- sram_addr output 32 SRAM address
- sram_wdata output 32 SRAM write data
- sram_rdata input 32 SRAM read data

Behaviour:
- Reset (asynchronous, active-high):
  - State is IDLE, latency counter is 0, streak counter is 0, owner register is 0.
  - While reset is asserted, every output is 0.
  - If reset arrives during a read, the read is dropped and no rvalid is produced afterwards.
- States:
  - IDLE: no access outstanding.
  - WAIT: a read is outstanding; cnt counts down from RD_LAT-1; owner records IF or MEM.
- Arbitration occurs in IDLE, and in WAIT in the cycle where cnt==0 (the response cycle).
  - If mem_req and not (if_req and streak==MAX_STREAK): grant MEM.
  - Else if if_req: grant IF.
- Grant cycle (combinational from current inputs):
  - The granted gnt is 1 and sram_en=1.
  - sram_addr is the granted address.
  - For a MEM store: sram_we=mem_wstrb and sram_wdata=mem_wdata. Otherwise sram_we=0.
  - At most one gnt is high per cycle.
  - When no grant occurs: sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0.
- After a grant:
  - Read: next state WAIT, cnt=RD_LAT-1, owner=requester.
  - Store: next state IDLE. A store produces no rvalid.
- WAIT:
  - When cnt>0: decrement cnt, no grant.
  - When cnt==0: pulse the owner's rvalid for 1 cycle, with rdata=sram_rdata (combinational). In the same cycle, arbitrate: a new read grant reloads WAIT, otherwise go to IDLE.
- Latency: a read granted in cycle T gives rvalid in cycle T+RD_LAT. A back-to-back grant is allowed in cycle T+RD_LAT.
- if_rdata and mem_rdata are 0 when their rvalid is 0.
- Streak counter:
  - A MEM grant while if_req=1 increments it, saturating at MAX_STREAK.
  - A MEM grant while if_req=0, or any IF grant, clears it to 0.
- mem_wstrb=0 on a store still consumes a grant cycle with sram_en=1 and sram_we=0.

Test Plan:
- RD_LAT=1. if_req with if_addr=0x1c000000 in IDLE → if_gnt and sram_en high in cycle T, sram_addr=0x1c000000. In T+1, sram_rdata=0x02800c0c gives if_rvalid=1, if_rdata=0x02800c0c, state back to IDLE.
- if_req and mem_req both high in IDLE, mem_wr=0, mem_addr=0x100 → mem_gnt first. if_gnt comes in the mem_rvalid cycle, back-to-back with sram_addr switching to if_addr.
- Store with mem_wstrb=0b0011, mem_wdata=0xAABBCCDD, addr 0x200 → one-cycle grant, sram_we=0011, no rvalid on either port. A following if_req is granted the next cycle.
- MAX_STREAK=4, if_req and mem_req held high continuously with loads → grant order MEM,MEM,MEM,MEM,IF,MEM…; streak returns to 0 after the IF grant.
- RD_LAT=3. Load granted in T → no grants in T+1 and T+2, mem_rvalid in T+3. Asserting reset in T+1 → no rvalid is ever produced, all outputs are 0, and the post-reset state is IDLE.
